// File: rtl/whack_if.sv
// Bundle between the game display/controls and the whack responder.
interface whack_if;
    logic       enable;
    logic [6:0] seg_n;
    logic       game_over;
    logic [7:0] btn;
    logic [7:0] press_cnt;
    logic [7:0] miss_cnt;
    logic       busy;

    modport master (
        output enable, seg_n, game_over,
        input  btn, press_cnt, miss_cnt, busy
    );

    modport slave (
        input  enable, seg_n, game_over,
        output btn, press_cnt, miss_cnt, busy
    );
endinterface

// File: rtl/whack_responder.sv
// Watches the game's segment display, waits for a stable pattern, reacts after a
// fixed delay and presses the matching buttons, retrying if the pattern lingers.
module whack_responder #(
    parameter int STABLE_CYCLES   = 2,
    parameter int REACT_CYCLES    = 8,
    parameter int HOLD_CYCLES     = 3,
    parameter int RELEASE_TIMEOUT = 64,
    parameter int MISS_EVERY      = 0
) (
    input  logic    clk,
    input  logic    rst_n,
    whack_if.slave  io
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        REACT   = 3'd2,
        PRESS   = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam int MAX_A = (STABLE_CYCLES > REACT_CYCLES) ? STABLE_CYCLES : REACT_CYCLES;
    localparam int MAX_B = (HOLD_CYCLES > RELEASE_TIMEOUT) ? HOLD_CYCLES : RELEASE_TIMEOUT;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_C + 1);
    localparam int FW    = $clog2(MISS_EVERY + 2);

    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] REACT_LAST   = CW'(REACT_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [FW-1:0] FRESH_LAST   = FW'((MISS_EVERY > 0) ? MISS_EVERY - 1 : 0);
    localparam logic [FW-1:0] FRESH_ONE    = FW'(1);
    localparam bit            MISS_EN      = (MISS_EVERY != 0);

    // A miss presses the lowest unlit segment position instead of the target.
    function automatic logic [6:0] lowest_zero_onehot(input logic [6:0] t);
        logic [6:0] r;
        r = 7'h00;
        for (int i = 6; i >= 0; i--) begin
            if (!t[i]) begin
                r    = 7'h00;
                r[i] = 1'b1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [6:0]      target_q, target_d;
    logic            retry_q, retry_d;
    logic [FW-1:0]   fresh_q, fresh_d;
    logic [7:0]      btn_q, btn_d;
    logic [7:0]      press_q, press_d;
    logic [7:0]      miss_q, miss_d;
    logic            busy_q, busy_d;

    logic [6:0]      lit_s;
    logic            abort_s;
    logic            press_entry_s;
    logic            miss_slot_s;
    logic            miss_s;
    logic [6:0]      mask_s;

    assign lit_s         = ~io.seg_n;
    assign abort_s       = io.game_over | ~io.enable;
    assign press_entry_s = (state_q == REACT) && (state_d == PRESS);
    assign miss_slot_s   = MISS_EN && !retry_q && (fresh_q == FRESH_LAST);
    assign miss_s        = miss_slot_s && (target_q != 7'h7F);
    assign mask_s        = miss_s ? lowest_zero_onehot(target_q) : target_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            target_q <= 7'h00;
            retry_q  <= 1'b0;
            fresh_q  <= '0;
            btn_q    <= 8'h00;
            press_q  <= 8'h00;
            miss_q   <= 8'h00;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            retry_q  <= retry_d;
            fresh_q  <= fresh_d;
            btn_q    <= btn_d;
            press_q  <= press_d;
            miss_q   <= miss_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic; one counter serves every timed state since each entry clears it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        retry_d  = retry_q;
        if (abort_s) begin
            state_d = IDLE;
            cnt_d   = '0;
            retry_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lit_s != 7'h00) begin
                        target_d = lit_s;
                        cnt_d    = '0;
                        state_d  = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SETTLE: begin
                    if (lit_s == 7'h00) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        retry_d = 1'b0;
                    end else if (lit_s != target_q) begin
                        target_d = lit_s;
                        cnt_d    = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = REACT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                REACT: begin
                    if (lit_s != target_q) begin
                        state_d  = SETTLE;
                        target_d = lit_s;
                        cnt_d    = '0;
                    end else if (cnt_q == REACT_LAST) begin
                        state_d = PRESS;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                PRESS: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                RELEASE: begin
                    if (lit_s != target_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        retry_d = 1'b0;
                    end else if (cnt_q == RELEASE_LAST) begin
                        state_d = REACT;
                        cnt_d   = '0;
                        retry_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    retry_d = 1'b0;
                end
            endcase
        end
    end

    // Output logic: button drive is loaded on PRESS entry and held only while in PRESS.
    always_comb begin
        btn_d   = 8'h00;
        press_d = press_q;
        miss_d  = miss_q;
        fresh_d = fresh_q;
        busy_d  = (state_d != IDLE);
        if (press_entry_s) begin
            btn_d   = {1'b0, mask_s};
            press_d = sat_inc(press_q);
            if (MISS_EN && !retry_q) begin
                fresh_d = miss_slot_s ? '0 : fresh_q + FRESH_ONE;
            end else begin
                fresh_d = fresh_q;
            end
            if (miss_s) begin
                miss_d = sat_inc(miss_q);
            end else begin
                miss_d = miss_q;
            end
        end else if (state_d == PRESS) begin
            btn_d = btn_q;
        end else begin
            btn_d = 8'h00;
        end
    end

    assign io.btn       = btn_q;
    assign io.press_cnt = press_q;
    assign io.miss_cnt  = miss_q;
    assign io.busy      = busy_q;
endmodule

// File: tb/tb_whack_responder.sv
// Two responders (MISS_EVERY=2 and MISS_EVERY=1) share stimulus and are compared
// every cycle against a countdown-based model, plus directed literal expectations.
module tb_whack_responder;
    localparam int STABLE = 2;
    localparam int REACT  = 8;
    localparam int HOLD   = 3;
    localparam int TMO    = 64;

    localparam int P_IDLE = 0, P_SETTLE = 1, P_REACT = 2, P_PRESS = 3, P_RELEASE = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       go;
    logic [6:0] seg;

    int n_checks = 0;
    int n_errors = 0;

    whack_if if0 ();
    whack_if if1 ();

    assign if0.enable = en;
    assign if0.seg_n = seg;
    assign if0.game_over = go;
    assign if1.enable = en;
    assign if1.seg_n = seg;
    assign if1.game_over = go;

    whack_responder #(.MISS_EVERY(2)) u0 (.clk(clk), .rst_n(rst_n), .io(if0));
    whack_responder #(.MISS_EVERY(1)) u1 (.clk(clk), .rst_n(rst_n), .io(if1));

    always #5 clk = ~clk;

    // model state, one slot per DUT
    int         ph    [2];
    int         left  [2];
    logic [6:0] tgt   [2];
    bit         rty   [2];
    int         fresh [2];
    logic [7:0] mbtn  [2];
    logic [7:0] mpc   [2];
    logic [7:0] mmc   [2];
    bit         mbusy [2];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_press(input int k, input int me);
        logic [6:0] mask;
        int b;
        mask = tgt[k];
        if (!rty[k] && me != 0) begin
            fresh[k]++;
            if (fresh[k] == me) begin
                fresh[k] = 0;
                if (tgt[k] != 7'h7F) begin
                    b = 0;
                    while (tgt[k][b]) b++;
                    mask = 7'(1 << b);
                    if (mmc[k] != 8'd255) mmc[k] = mmc[k] + 8'd1;
                end
            end
        end
        mbtn[k] = {1'b0, mask};
        if (mpc[k] != 8'd255) mpc[k] = mpc[k] + 8'd1;
        ph[k]   = P_PRESS;
        left[k] = HOLD;
    endtask

    task automatic model_step(input int k, input int me, input bit r, input bit e,
                              input bit g, input logic [6:0] lit);
        if (!r) begin
            ph[k] = P_IDLE; left[k] = 0; tgt[k] = 7'h00; rty[k] = 1'b0; fresh[k] = 0;
            mbtn[k] = 8'h00; mpc[k] = 8'h00; mmc[k] = 8'h00;
        end else if (!e || g) begin
            ph[k] = P_IDLE; mbtn[k] = 8'h00; rty[k] = 1'b0;
        end else begin
            case (ph[k])
                P_IDLE: if (lit != 7'h00) begin
                    tgt[k] = lit; left[k] = STABLE; ph[k] = P_SETTLE;
                end
                P_SETTLE: if (lit == 7'h00) begin
                    ph[k] = P_IDLE; rty[k] = 1'b0;
                end else if (lit != tgt[k]) begin
                    tgt[k] = lit; left[k] = STABLE;
                end else begin
                    left[k]--;
                    if (left[k] == 0) begin ph[k] = P_REACT; left[k] = REACT; end
                end
                P_REACT: if (lit != tgt[k]) begin
                    ph[k] = P_SETTLE; tgt[k] = lit; left[k] = STABLE;
                end else begin
                    left[k]--;
                    if (left[k] == 0) do_press(k, me);
                end
                P_PRESS: begin
                    left[k]--;
                    if (left[k] == 0) begin mbtn[k] = 8'h00; ph[k] = P_RELEASE; left[k] = TMO; end
                end
                P_RELEASE: if (lit != tgt[k]) begin
                    ph[k] = P_IDLE; rty[k] = 1'b0;
                end else begin
                    left[k]--;
                    if (left[k] == 0) begin ph[k] = P_REACT; left[k] = REACT; rty[k] = 1'b1; end
                end
                default: ph[k] = P_IDLE;
            endcase
        end
        mbusy[k] = (ph[k] != P_IDLE);
    endtask

    // per-cycle compare against the model, 1 time unit after each rising edge
    initial begin
        bit r, e, g;
        logic [6:0] l;
        forever begin
            @(posedge clk);
            r = rst_n; e = en; g = go; l = ~seg;
            #1;
            model_step(0, 2, r, e, g, l);
            model_step(1, 1, r, e, g, l);
            chk("m0_btn",   if0.btn,          mbtn[0]);
            chk("m0_press", if0.press_cnt,    mpc[0]);
            chk("m0_miss",  if0.miss_cnt,     mmc[0]);
            chk("m0_busy",  {7'd0, if0.busy}, {7'd0, mbusy[0]});
            chk("m1_btn",   if1.btn,          mbtn[1]);
            chk("m1_press", if1.press_cnt,    mpc[1]);
            chk("m1_miss",  if1.miss_cnt,     mmc[1]);
            chk("m1_busy",  {7'd0, if1.busy}, {7'd0, mbusy[1]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; go = 1'b0; seg = 7'h7F;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_btn(input string name, input int budget);
        int n = 0;
        while (if0.btn == 8'h00 && n < budget) begin tick(); n++; end
        n_checks++;
        if (if0.btn == 8'h00) begin
            n_errors++;
            $display("FAIL %s actual=timeout expected=press within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((if0.busy || if0.btn != 8'h00) && n < budget) begin tick(); n++; end
        n_checks++;
        if (if0.busy || if0.btn != 8'h00) begin
            n_errors++;
            $display("FAIL %s actual=busy expected=idle within %0d cycles", name, budget);
        end
    endtask

    initial begin
        logic [7:0] seen;
        rst_n = 1'b0; en = 1'b0; go = 1'b0; seg = 7'h7F;
        tick(); tick();
        chk("rst_btn", if0.btn, 8'h00);
        chk("rst_press", if0.press_cnt, 8'h00);
        chk("rst_miss", if0.miss_cnt, 8'h00);
        chk("rst_busy", {7'd0, if0.busy}, 8'h00);
        rst_n = 1'b1;

        // basic latency: sampled at E0, press E10..E13
        en = 1'b1; tick();
        seg = 7'b1111011; tick();
        repeat (9) tick();
        chk("s1_e9", if0.btn, 8'h00);
        tick();
        chk("s1_e10", if0.btn, 8'h04);
        repeat (2) tick();
        chk("s1_e12", if0.btn, 8'h04);
        tick();
        chk("s1_e13", if0.btn, 8'h00);
        chk("s1_press", if0.press_cnt, 8'd1);
        seg = 7'h7F; tick();
        chk("s1_idle", {7'd0, if0.busy}, 8'h00);

        // pattern change during REACT restarts settling
        do_reset(); en = 1'b1; tick();
        seg = 7'b1111110; tick();
        repeat (4) tick();
        seg = 7'b1110111; tick();
        repeat (9) tick();
        chk("s2_pre", if0.btn, 8'h00);
        tick();
        chk("s2_btn", if0.btn, 8'h08);
        chk("s2_press", if0.press_cnt, 8'd1);
        seg = 7'h7F; wait_idle("s2_idle", 20);

        // miss on second fresh target, then retry presses the real target
        do_reset(); en = 1'b1; tick();
        seg = ~7'h01; wait_btn("s3_w1", 30);
        chk("s3_btn1", if0.btn, 8'h01);
        seg = 7'h7F; wait_idle("s3_idle", 20);
        seg = ~7'h03; wait_btn("s3_w2", 30);
        chk("s3_btn2", if0.btn, 8'h04);
        chk("s3_miss", if0.miss_cnt, 8'd1);
        chk("s3_u1btn2", if1.btn, 8'h04);
        while (if0.btn != 8'h00) tick();
        wait_btn("s3_w3", 120);
        chk("s3_retry", if0.btn, 8'h03);
        chk("s3_press", if0.press_cnt, 8'd3);
        chk("s3_miss2", if0.miss_cnt, 8'd1);
        seg = 7'h7F; wait_idle("s3_idle2", 20);

        // game_over mid-press aborts at the next edge
        do_reset(); en = 1'b1; tick();
        seg = ~7'h05; wait_btn("s4_w", 30);
        go = 1'b1; tick();
        chk("s4_btn", if0.btn, 8'h00);
        chk("s4_busy", {7'd0, if0.busy}, 8'h00);
        seen = 8'h00;
        repeat (30) begin tick(); seen = seen | if0.btn | if1.btn; end
        chk("s4_nopress", seen, 8'h00);
        chk("s4_press", if0.press_cnt, 8'd1);
        go = 1'b0; seg = 7'h7F; tick();

        // async reset mid-press
        seg = ~7'h11; wait_btn("s5_w", 30);
        rst_n = 1'b0; #1;
        chk("s5_btn", if0.btn, 8'h00);
        chk("s5_press", if0.press_cnt, 8'h00);
        chk("s5_miss1", if1.miss_cnt, 8'h00);
        seg = 7'h7F; tick();
        rst_n = 1'b1; repeat (3) tick();
        chk("s5_busy", {7'd0, if0.busy}, 8'h00);

        // all-lit target never misses; press counter saturates
        do_reset(); en = 1'b1; tick();
        for (int i = 0; i < 256; i++) begin
            seg = 7'h00; wait_btn("s6_w", 30);
            if (i == 0) begin
                chk("s6_u1btn", if1.btn, 8'h7F);
                chk("s6_u1miss", if1.miss_cnt, 8'h00);
            end
            seg = 7'h7F; wait_idle("s6_idle", 20);
        end
        chk("s6_press0", if0.press_cnt, 8'd255);
        chk("s6_press1", if1.press_cnt, 8'd255);
        chk("s6_miss1", if1.miss_cnt, 8'h00);

        // random stimulus, checked by the per-cycle model compare
        do_reset(); en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 3) begin
                case ($urandom_range(0, 4))
                    0:       seg = 7'h7F;
                    1:       seg = 7'h00;
                    2:       seg = ~7'h01;
                    3:       seg = ~7'h03;
                    default: seg = 7'($urandom);
                endcase
            end
            en = ($urandom_range(0, 199) != 0);
            go = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/whack_responder.md
WHACK_RESPONDER -- requirements
Module: whack_responder

Interface
REQ-001 The block SHALL provide these parameters:
- STABLE_CYCLES, default 2, consecutive matching samples needed before a pattern counts as valid.
- REACT_CYCLES, default 8, reaction delay in cycles (minimum 1).
- HOLD_CYCLES, default 3, cycles the button mask is held (minimum 1).
- RELEASE_TIMEOUT, default 64, cycles to wait for the pattern to change before retrying.
- MISS_EVERY, default 0, deliberate wrong press on every Nth fresh target (0 disables).

REQ-002 The block SHALL provide these ports (clock and reset first):
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  responder active.
- seg_n  in  7  active-low segment pattern from the game display.
- game_over  in  1  game finished; stop pressing.
- btn  out  8  registered button drive to the game, active-high.
- press_cnt  out  8  number of PRESS entries, saturating.
- miss_cnt  out  8  number of deliberate wrong presses, saturating.
- busy  out  1  high whenever the state is not IDLE.

Function
REQ-003 lit SHALL equal ~seg_n, and all comparisons SHALL use lit.
REQ-004 The FSM SHALL have exactly five states: IDLE, SETTLE, REACT, PRESS, RELEASE.
REQ-005 IDLE: btn SHALL be 0; if enable && !game_over && lit!=0, the FSM SHALL latch target<=lit, clear the stability counter and go to SETTLE.
REQ-006 SETTLE:
- lit==0: go to IDLE.
- lit!=target: set target<=lit and restart the count.
- Otherwise: increment the count; on the STABLE_CYCLES-th consecutive match, go to REACT with the react counter cleared.
REQ-007 REACT:
- lit!=target: return to SETTLE, reloading target<=lit.
- Otherwise: count cycles; at the edge completing REACT_CYCLES, go to PRESS.
REQ-008 PRESS entry edge:
- btn<={1'b0,mask}.
- press_cnt increments, saturating at 255.
- btn SHALL stay constant for exactly HOLD_CYCLES cycles, regardless of lit.
- After HOLD_CYCLES, btn<=0 and the FSM goes to RELEASE.
REQ-009 btn[7] SHALL always be 0.
REQ-010 mask SHALL equal target, except on a miss press.
REQ-011 Miss press:
- Occurs when MISS_EVERY!=0, this is a fresh target (not a retry), and this is the MISS_EVERY-th fresh target since reset.
- mask SHALL be a one-hot at the lowest bit index i in 0..6 where target[i]==0.
- miss_cnt increments, saturating at 255.
- If target==7'h7F, no miss SHALL occur; mask=target and miss_cnt is unchanged.
REQ-012 The fresh-target counter SHALL wrap to 0 after reaching MISS_EVERY and SHALL NOT advance on retries.
REQ-013 RELEASE: btn SHALL be 0.
- lit!=target, including lit==0: go to IDLE.
- lit==target for RELEASE_TIMEOUT cycles: go to REACT with target kept and the retry flag set; the retry press SHALL use mask=target.
REQ-014 The retry flag SHALL clear on entry to IDLE.
REQ-015 Abort: game_over==1 or enable==0 sampled at any edge SHALL force state<=IDLE and btn<=0 at that same edge. Abort SHALL take priority over every other transition.
REQ-016 Latency (STABLE=2, REACT=8): with a pattern first sampled in IDLE at edge E0, btn SHALL assert at edge E10 and deassert at edge E13.
REQ-017 press_cnt and miss_cnt SHALL hold their values across aborts and SHALL clear only on reset.

Reset
REQ-018 While rst_n==0 the block SHALL hold: state IDLE, btn=0, press_cnt=0, miss_cnt=0, target=0, all counters 0, retry flag=0, busy=0.
REQ-019 Reset asserted mid-PRESS SHALL clear btn asynchronously, without waiting for a clock edge.
REQ-020 After reset release, the first possible transition SHALL be at the first clock edge.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- enable=1, seg_n=7'b1111011 held → btn=8'h04 from edge E10 to edge E13; press_cnt=1; then seg_n=7'h7F → IDLE, busy=0.
- seg_n changes from 7'b1111110 to 7'b1110111 at edge E5 (in REACT) → return to SETTLE; btn=8'h08 asserted 10 edges after the change; press_cnt=1.
- MISS_EVERY=2, targets 7'h01 then 7'h03, each cleared after release → first btn=8'h01; second btn=8'h04 with miss_cnt=1; pattern 7'h03 held for 64 cycles → retry btn=8'h03, press_cnt=3, miss_cnt=1.
- game_over raised during PRESS → btn=0 and state IDLE at the next edge; no further presses while game_over=1.
- rst_n pulsed low mid-PRESS → btn=0 immediately; counters 0; after release with lit=0, busy stays 0.
- Target 7'h7F with MISS_EVERY=1 → mask=7'h7F, miss_cnt stays 0; 256 completed presses → press_cnt stays at 255.
